syn_input_scheduler: RTL and testbench
======================================

# syn_input_scheduler

Round-robin scheduler that shares the neuron datapath's single 8-bit synaptic current input (`I_syn` of the membrane decoder) among several synaptic requesters. Each grant drives the granted channel's weight onto `I_syn` for a fixed dwell window. The block watches the returned membrane voltage `V_mem` and enforces a refractory period after each threshold crossing. It sits between the user input/IO pins and the decoder inside the top-level tile.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting channels (2..8).
- `W`, 8: width of weights, `I_syn` and `V_mem`.
- `DWELL`, 4: cycles each grant drives `I_syn` (≥1).
- `THRESH`, 8'd200: spike threshold; `V_mem >= THRESH` is a spike.
- `REFRAC`, 16: refractory length in cycles (≥1).

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in NUM_CH: per-channel request; the requester holds it until granted.
- `weight` in NUM_CH*W: channel k weight in bits [k*W +: W]; it must be stable while `req[k]` is high.
- `gnt` out NUM_CH: one-hot, one-cycle pulse; the weight was captured.
- `I_syn` out W: registered current to the decoder.
- `V_mem` in W: membrane voltage from the decoder.
- `spike` out 1: one-cycle pulse on a detected threshold crossing.
- `busy` out 1: high in DRIVE.
- `refrac` out 1: high in REFRACT.

## Operation
- States: IDLE, DRIVE, REFRACT.
- **IDLE**
  - `I_syn` = 0.
  - If `req` ≠ 0: grant the first requesting channel at or after `ptr`, searching in ascending order with wrap.
  - On a grant: `gnt[k]` pulses, `I_syn` ← weight k, `dwell_cnt` ← DWELL-1, `ptr` ← k+1 mod NUM_CH, go to DRIVE.
- **DRIVE**
  - `I_syn` holds.
  - While `dwell_cnt` > 0, `dwell_cnt` decrements.
  - At `dwell_cnt` = 0 with a request pending: grant immediately (back-to-back, same rules as IDLE) and stay in DRIVE.
  - At `dwell_cnt` = 0 with no request pending: `I_syn` ← 0, go to IDLE.
- **Spike detection**
  - `V_mem` is sampled into a register every cycle.
  - If the sampled value is ≥ THRESH while not in REFRACT: `spike` pulses, `I_syn` ← 0, `ref_cnt` ← REFRAC-1, go to REFRACT.
  - Any grant due on that edge is suppressed; spike beats grant.
  - An aborted drive is not resumed; that channel must re-request, and `ptr` stays past it.
- **REFRACT**
  - `I_syn` = 0, no grants, `V_mem` is ignored.
  - At `ref_cnt` = 0, go to IDLE.
- A request that drops before it is granted is discarded silently.
- `weight` passes to `I_syn` unchanged; there is no scaling or saturation.

## Timing
- Reset (async assert, sync release):
  - state IDLE, `ptr` = 0, counters 0.
  - `I_syn` = 0, `gnt` = 0, `spike` = 0, `busy` = 0, `refrac` = 0.
- Grant latency: `req` seen high at edge N → `gnt` and `I_syn` valid after edge N.
- `I_syn` holds a granted weight for exactly DWELL cycles. Back-to-back grants leave no zero cycle between weights.
- Spike latency: `V_mem` ≥ THRESH at edge N is registered at N. The compare fires at edge N+1, so `spike`=1, `I_syn`=0 and `refrac`=1 all appear after edge N+1.
- REFRACT lasts exactly REFRAC cycles. The earliest next grant is the edge that leaves REFRACT plus one.
- `rst_n` asserted mid-DRIVE or mid-REFRACT: outputs go to reset values immediately, with no `spike` and no `gnt`.

## Configuration
- Macro `SYN_SCHED_SPIKE_CNT_EN`.
- Defined: adds output `spike_cnt` (16 bits), reset to 0. It increments on each `spike` pulse and wraps from 0xFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `syn_sched_pkg`:
  - state enum (IDLE, DRIVE, REFRACT);
  - default constants for NUM_CH, W, DWELL, THRESH, REFRAC;
  - the counter-width helper.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are `req` and `ptr`; outputs are a one-hot grant and a `valid` flag. The scheduler FSM owns `ptr` and all registers.

## Test plan
- Reset with `req`=4'b1111 → `gnt` sequence 0001, 0010, 0100, 1000, 0001, each 4 cycles apart; `I_syn` steps through the four weights with no zero gaps.
- Single `req[2]`, weight 8'd50, pulsed once → `gnt`=0100 for 1 cycle; `I_syn`=50 for 4 cycles, then 0; `busy` falls with it.
- Mid-DRIVE, `V_mem`=8'd200 → 2 cycles later `spike`=1 for 1 cycle, `I_syn`=0, `refrac`=1 for 16 cycles; `req` held throughout gets no `gnt` until after REFRACT.
- `V_mem`=8'd199 held for 100 cycles → no spike; `V_mem`=8'd255 during REFRACT → no second spike.
- `rst_n` low mid-REFRACT → all outputs 0 at once; `ptr` back to 0 (channel 0 wins the first grant).
- With `SYN_SCHED_SPIKE_CNT_EN` defined, 65537 spikes → `spike_cnt`=1.

Source files
------------

// File: rtl/syn_input_scheduler_pkg.sv
// Shared types and defaults for the synaptic input scheduler.
package syn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    REFRACT = 2'd2
  } sched_state_e;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_W      = 8;
  localparam int unsigned DEF_DWELL  = 4;
  localparam int unsigned DEF_THRESH = 200;
  localparam int unsigned DEF_REFRAC = 16;

  // Bits needed to hold a down-counter or index in the range 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/syn_input_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, ascending with wrap.
module rr_arbiter
  import syn_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned PTR_W  = cnt_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic              valid
);

  // Search the upper segment [ptr..NUM_CH-1] first, then wrap to the bottom.
  always_comb begin : pick
    logic w_hit_hi;
    logic w_hit_lo;
    gnt      = '0;
    valid    = |req;
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (!w_hit_hi && req[j] && (j >= 32'(ptr))) begin
        gnt[j]   = 1'b1;
        w_hit_hi = 1'b1;
      end
    end
    if (!w_hit_hi) begin
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!w_hit_lo && req[j]) begin
          gnt[j]   = 1'b1;
          w_hit_lo = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/syn_input_scheduler.sv
// Round-robin I_syn scheduler with dwell window and post-spike refractory period.
// Optional spike_cnt output is enabled by defining SYN_SCHED_SPIKE_CNT_EN.
module syn_input_scheduler
  import syn_sched_pkg::*;
#(
  parameter int unsigned   NUM_CH = DEF_NUM_CH,
  parameter int unsigned   W      = DEF_W,
  parameter int unsigned   DWELL  = DEF_DWELL,
  parameter logic [W-1:0]  THRESH = W'(DEF_THRESH),
  parameter int unsigned   REFRAC = DEF_REFRAC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*W-1:0]   weight,
  output logic [NUM_CH-1:0]     gnt,
  output logic [W-1:0]          I_syn,
  input  logic [W-1:0]          V_mem,
  output logic                  spike,
  output logic                  busy,
  output logic                  refrac
`ifdef SYN_SCHED_SPIKE_CNT_EN
  ,
  output logic [15:0]           spike_cnt
`endif
);

  localparam int unsigned PTR_W = cnt_w(NUM_CH);
  localparam int unsigned DW_W  = cnt_w(DWELL);
  localparam int unsigned RF_W  = cnt_w(REFRAC);

  sched_state_e       r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt, w_ptr_adv;
  logic [DW_W-1:0]    r_dwell, w_dwell_nxt;
  logic [RF_W-1:0]    r_ref, w_ref_nxt;
  logic [W-1:0]       r_vmem;
  logic [W-1:0]       r_isyn, w_isyn_nxt, w_wsel;
  logic [NUM_CH-1:0]  r_gnt, w_gnt_nxt, w_arb_gnt;
  logic               r_spike, w_spike_nxt;
  logic               w_arb_valid, w_do_grant, w_spike_det;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .gnt   (w_arb_gnt),
    .valid (w_arb_valid)
  );

  always_comb begin
    w_wsel    = '0;
    w_ptr_adv = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (w_arb_gnt[k]) begin
        w_wsel    = weight[k*W +: W];
        w_ptr_adv = (k == NUM_CH - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_dwell_nxt = r_dwell;
    w_ref_nxt   = r_ref;
    w_isyn_nxt  = r_isyn;
    w_gnt_nxt   = '0;
    w_spike_nxt = 1'b0;
    w_do_grant  = 1'b0;
    w_spike_det = (r_state != REFRACT) && (r_vmem >= THRESH);

    unique case (r_state)
      IDLE: begin
        w_isyn_nxt = '0;
        w_do_grant = w_arb_valid;
      end
      DRIVE: begin
        if (r_dwell != '0) begin
          w_dwell_nxt = r_dwell - DW_W'(1);
        end else if (w_arb_valid) begin
          w_do_grant = 1'b1;
        end else begin
          w_isyn_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      REFRACT: begin
        w_isyn_nxt = '0;
        if (r_ref == '0) w_state_nxt = IDLE;
        else             w_ref_nxt   = r_ref - RF_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase

    // A spike overrides any grant due on the same edge; ptr already sits past an aborted channel.
    if (w_spike_det) begin
      w_spike_nxt = 1'b1;
      w_isyn_nxt  = '0;
      w_ref_nxt   = RF_W'(REFRAC - 1);
      w_state_nxt = REFRACT;
    end else if (w_do_grant) begin
      w_gnt_nxt   = w_arb_gnt;
      w_isyn_nxt  = w_wsel;
      w_dwell_nxt = DW_W'(DWELL - 1);
      w_ptr_nxt   = w_ptr_adv;
      w_state_nxt = DRIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_dwell <= '0;
      r_ref   <= '0;
      r_vmem  <= '0;
      r_isyn  <= '0;
      r_gnt   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dwell <= w_dwell_nxt;
      r_ref   <= w_ref_nxt;
      r_vmem  <= V_mem;
      r_isyn  <= w_isyn_nxt;
      r_gnt   <= w_gnt_nxt;
      r_spike <= w_spike_nxt;
    end
  end

`ifdef SYN_SCHED_SPIKE_CNT_EN
  logic [15:0] r_spike_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_spike_cnt <= '0;
    else if (w_spike_nxt) r_spike_cnt <= r_spike_cnt + 16'd1;
  end

  assign spike_cnt = r_spike_cnt;
`endif

  assign gnt    = r_gnt;
  assign I_syn  = r_isyn;
  assign spike  = r_spike;
  assign busy   = (r_state == DRIVE);
  assign refrac = (r_state == REFRACT);

endmodule

// File: tb/tb_syn_input_scheduler.sv
// Directed, table-driven bench for syn_input_scheduler (default parameters).
module tb_syn_input_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] weight;
  logic [3:0]  gnt;
  logic [7:0]  I_syn;
  logic [7:0]  V_mem;
  logic        spike;
  logic        busy;
  logic        refrac;
`ifdef SYN_SCHED_SPIKE_CNT_EN
  logic [15:0] spike_cnt;
`endif

  syn_input_scheduler #(
    .NUM_CH (4),
    .W      (8),
    .DWELL  (4),
    .THRESH (8'd200),
    .REFRAC (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .weight (weight),
    .gnt    (gnt),
    .I_syn  (I_syn),
    .V_mem  (V_mem),
    .spike  (spike),
    .busy   (busy),
    .refrac (refrac)
`ifdef SYN_SCHED_SPIKE_CNT_EN
    ,
    .spike_cnt (spike_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] vmem;
    logic [3:0] e_gnt;
    logic [7:0] e_isyn;
    logic       e_spike;
    logic       e_busy;
    logic       e_refrac;
  } vec_t;

  vec_t tbl[$];
  int   n_err;
  int   n_chk;
  logic [7:0] wv [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [7:0] i,
                            input logic s, input logic b, input logic r);
    chk({tag, ".gnt"},    32'(gnt),    32'(g));
    chk({tag, ".I_syn"},  32'(I_syn),  32'(i));
    chk({tag, ".spike"},  32'(spike),  32'(s));
    chk({tag, ".busy"},   32'(busy),   32'(b));
    chk({tag, ".refrac"}, 32'(refrac), 32'(r));
  endtask

  task automatic apply(input logic [3:0] rq, input logic [7:0] v);
    req   = rq;
    V_mem = v;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [3:0] rq, input logic [7:0] v, input logic [3:0] g,
                              input logic [7:0] i, input logic s, input logic b, input logic r);
    vec_t e;
    e.req = rq; e.vmem = v; e.e_gnt = g; e.e_isyn = i;
    e.e_spike = s; e.e_busy = b; e.e_refrac = r;
    tbl.push_back(e);
  endfunction

  initial begin
    n_err  = 0;
    n_chk  = 0;
    wv[0] = 8'd11; wv[1] = 8'd22; wv[2] = 8'd50; wv[3] = 8'd44;
    weight = {wv[3], wv[2], wv[1], wv[0]};
    req    = '0;
    V_mem  = '0;
    rst_n  = 1'b0;

    // All four requesting from reset: grants rotate every DWELL cycles, no zero gaps.
    for (int c = 1; c <= 17; c++) begin
      int slot;
      slot = ((c - 1) / 4) % 4;
      add(4'b1111, 8'd0, ((c - 1) % 4 == 0) ? 4'(1 << slot) : 4'b0000, wv[slot], 1'b0, 1'b1, 1'b0);
    end
    for (int c = 0; c < 3; c++) add(4'b0000, 8'd0, 4'b0000, 8'd11, 1'b0, 1'b1, 1'b0);
    add(4'b0000, 8'd0, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
    // Single pulsed request on channel 2 (ptr is at 1).
    add(4'b0100, 8'd0, 4'b0100, 8'd50, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) add(4'b0000, 8'd0, 4'b0000, 8'd50, 1'b0, 1'b1, 1'b0);
    add(4'b0000, 8'd0, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
    add(4'b0000, 8'd0, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    apply(4'b0000, 8'd0);
    expect_out("idle", 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].req, tbl[i].vmem);
      expect_out($sformatf("row%0d", i), tbl[i].e_gnt, tbl[i].e_isyn,
                 tbl[i].e_spike, tbl[i].e_busy, tbl[i].e_refrac);
    end

    // Spike mid-DRIVE with req held; V_mem=255 during REFRACT must not re-spike.
    apply(4'b1000, 8'd0);
    expect_out("sp_grant", 4'b1000, 8'd44, 1'b0, 1'b1, 1'b0);
    apply(4'b1000, 8'd200);
    expect_out("sp_reg", 4'b0000, 8'd44, 1'b0, 1'b1, 1'b0);
    apply(4'b1000, 8'd0);
    expect_out("sp_fire", 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      apply(4'b1000, (i >= 2 && i <= 8) ? 8'd255 : 8'd0);
      expect_out($sformatf("refr%0d", i), 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1);
    end
    apply(4'b1000, 8'd0);
    expect_out("refr_exit", 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
    apply(4'b1000, 8'd0);
    expect_out("refr_grant", 4'b1000, 8'd44, 1'b0, 1'b1, 1'b0);

    // Just below threshold for 100 cycles: never a spike.
    for (int i = 0; i < 100; i++) begin
      apply(4'b0000, 8'd199);
      chk($sformatf("v199_%0d.spike", i), 32'(spike), 32'd0);
    end
    apply(4'b0000, 8'd0);
    expect_out("v199_end", 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);

    // Grant ch1 (ptr moves to 2), spike, then reset mid-REFRACT.
    apply(4'b0010, 8'd0);
    expect_out("rs_grant", 4'b0010, 8'd22, 1'b0, 1'b1, 1'b0);
    apply(4'b0000, 8'd200);
    expect_out("rs_reg", 4'b0000, 8'd22, 1'b0, 1'b1, 1'b0);
    apply(4'b0000, 8'd0);
    expect_out("rs_fire", 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1);
`ifdef SYN_SCHED_SPIKE_CNT_EN
    chk("spike_cnt", 32'(spike_cnt), 32'd2);
`endif
    for (int i = 0; i < 3; i++) begin
      apply(4'b0000, 8'd0);
      expect_out($sformatf("rs_refr%0d", i), 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    expect_out("rs_async", 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
`ifdef SYN_SCHED_SPIKE_CNT_EN
    chk("spike_cnt_rst", 32'(spike_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    expect_out("rs_hold", 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    apply(4'b1111, 8'd0);
    expect_out("rs_ptr0", 4'b0001, 8'd11, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
